// File: rtl/mgmt_bus_pkg.sv
// Shared types and constants for the management bus initiator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mgmt_bus_pkg;

  // Frame decoder / bus transaction states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    WR      = 3'd3,
    RD_WAIT = 3'd4,
    RD_HOLD = 3'd5,
    DRAIN   = 3'd6
  } mgmt_state_t;

  // Header byte 0 carries the read flag in its MSB and addr[14:8] below it.
  localparam int MGMT_RD_FLAG_BIT = 7;
  localparam int MGMT_ADDR_BITS   = 15;

  typedef logic [MGMT_ADDR_BITS-1:0] mgmt_addr_t;

endpackage

// File: rtl/mgmt_bus_initiator.sv
// Decodes framed command bytes into single-byte rd_en/wr_en register-bus transactions with address auto-increment.
// Latency: wr_en/rd_en one cycle after the triggering byte or handshake; out_valid one cycle after rd_valid.
// Backpressure: out_valid/out_data held until out_ready; the next read is not issued until the held byte is taken.
module mgmt_bus_initiator
  import mgmt_bus_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        stall_err,
  output logic        proto_err
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  // Architectural state
  mgmt_state_t      r_state;
  mgmt_addr_t       r_addr;
  logic             r_rd_flag;
  logic             r_rd_en;
  mgmt_addr_t       r_rd_addr;
  logic             r_wr_en;
  mgmt_addr_t       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_stall_err;
  logic             r_proto_err;

  // Decoded per-cycle actions
  mgmt_state_t      w_next_state;
  logic             w_hdr_hi;
  logic             w_hdr_lo;
  logic             w_issue_rd;
  mgmt_addr_t       w_rd_addr_nxt;
  logic             w_issue_wr;
  logic             w_capture;
  logic             w_out_clr;
  logic             w_addr_inc;
  logic             w_proto_set;
  logic             w_err_clr;
  mgmt_addr_t       w_addr_p1;
  logic             w_in_wait;
  logic [CNT_W-1:0] w_cnt_inc;

  // 15-bit wrap-around increment; bit 15 of the bus address is never driven.
  assign w_addr_p1 = r_addr + mgmt_addr_t'(1);
  assign w_in_wait = (r_state == RD_WAIT) || (r_state == DRAIN);
  assign w_cnt_inc = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and transaction decode; frame_start outside IDLE/DRAIN restarts the header
  always_comb begin
    w_next_state  = r_state;
    w_hdr_hi      = 1'b0;
    w_hdr_lo      = 1'b0;
    w_issue_rd    = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_issue_wr    = 1'b0;
    w_capture     = 1'b0;
    w_out_clr     = 1'b0;
    w_addr_inc    = 1'b0;
    w_proto_set   = 1'b0;
    w_err_clr     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_err_clr = 1'b1;
          if (in_valid) begin
            // A byte arriving with frame_start is header byte 0.
            w_hdr_hi     = 1'b1;
            w_next_state = HDR_LO;
          end else begin
            w_next_state = HDR_HI;
          end
        end else if (in_valid) begin
          w_proto_set = 1'b1;
        end
      end

      DRAIN: begin
        // Only the outstanding read's return matters here; new frames are flagged but not started.
        if (frame_start) begin
          w_proto_set = 1'b1;
        end
        if (rd_valid) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        if (frame_start) begin
          w_proto_set = 1'b1;
          w_out_clr   = 1'b1;
          if (in_valid) begin
            w_hdr_hi     = 1'b1;
            w_next_state = HDR_LO;
          end else begin
            w_next_state = HDR_HI;
          end
        end else begin
          case (r_state)
            HDR_HI: begin
              if (frame_end) begin
                w_next_state = IDLE;
              end else if (in_valid) begin
                w_hdr_hi     = 1'b1;
                w_next_state = HDR_LO;
              end
            end

            HDR_LO: begin
              if (frame_end) begin
                w_next_state = IDLE;
              end else if (in_valid) begin
                w_hdr_lo = 1'b1;
                if (r_rd_flag) begin
                  w_issue_rd    = 1'b1;
                  w_rd_addr_nxt = {r_addr[MGMT_ADDR_BITS-1:8], in_data};
                  w_next_state  = RD_WAIT;
                end else begin
                  w_next_state = WR;
                end
              end
            end

            WR: begin
              // A final byte coinciding with frame_end is still written.
              if (in_valid) begin
                w_issue_wr = 1'b1;
                w_addr_inc = 1'b1;
              end
              if (frame_end) begin
                w_next_state = IDLE;
              end
            end

            RD_WAIT: begin
              if (frame_end && rd_valid) begin
                w_next_state = IDLE;
              end else if (frame_end) begin
                w_next_state = DRAIN;
              end else if (rd_valid) begin
                w_capture    = 1'b1;
                w_next_state = RD_HOLD;
              end
            end

            RD_HOLD: begin
              if (frame_end) begin
                w_out_clr    = 1'b1;
                w_next_state = IDLE;
              end else if (out_ready) begin
                w_out_clr     = 1'b1;
                w_addr_inc    = 1'b1;
                w_issue_rd    = 1'b1;
                w_rd_addr_nxt = w_addr_p1;
                w_next_state  = RD_WAIT;
              end
            end

            default: begin
              w_next_state = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Header latch and auto-incrementing transaction address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_rd_flag <= 1'b0;
    end else if (w_hdr_hi) begin
      r_rd_flag                  <= in_data[MGMT_RD_FLAG_BIT];
      r_addr[MGMT_ADDR_BITS-1:8] <= in_data[MGMT_RD_FLAG_BIT-1:0];
    end else if (w_hdr_lo) begin
      r_addr[7:0] <= in_data;
    end else if (w_addr_inc) begin
      r_addr <= w_addr_p1;
    end
  end

  // Read strobe; rd_addr only moves when rd_en fires so the responder can re-sample it while pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_issue_rd;
      if (w_issue_rd) begin
        r_rd_addr <= w_rd_addr_nxt;
      end
    end
  end

  // Write strobe with address/data registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_issue_wr;
      if (w_issue_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= in_data;
      end
    end
  end

  // Read-return holding register towards the front end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= rd_data;
    end else if (w_out_clr) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating read-wait counter, restarted by every issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_issue_rd) begin
      r_stall_cnt <= '0;
    end else if (w_in_wait) begin
      r_stall_cnt <= w_cnt_inc;
    end
  end

  // Sticky error flags, cleared only by a legal frame_start from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (w_err_clr) begin
      r_stall_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_in_wait && (w_cnt_inc == STALL_MAX)) begin
        r_stall_err <= 1'b1;
      end
      if (w_proto_set) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = {1'b0, r_rd_addr};
  assign wr_en     = r_wr_en;
  assign wr_addr   = {1'b0, r_wr_addr};
  assign wr_data   = r_wr_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);
  assign stall_err = r_stall_err;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mgmt_bus_initiator.sv
// Directed bench for mgmt_bus_initiator with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: out_ready driven explicitly by the stimulus.
module tb_mgmt_bus_initiator;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        frame_end;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        stall_err;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Bus monitor state
  logic [23:0] wq[$];
  int          rd_cnt     = 0;
  int          addr_viol  = 0;
  int          bit15_viol = 0;
  logic        ov_seen    = 1'b0;
  logic [15:0] last_rd_addr = 16'h0;

  mgmt_bus_initiator #(.STALL_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .stall_err   (stall_err),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record writes, count reads, and watch rd_addr stability on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd_addr = 16'h0;
    end else begin
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (rd_en) begin
        rd_cnt++;
        last_rd_addr = rd_addr;
      end else if (rd_addr !== last_rd_addr) begin
        addr_viol++;
      end
      if (rd_addr[15] || wr_addr[15]) bit15_viol++;
      if (out_valid) ov_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic fs, input logic fe, input logic iv, input logic [7:0] d);
    frame_start = fs;
    frame_end   = fe;
    in_valid    = iv;
    in_data     = d;
    tick(1);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic respond(input int lat, input logic [7:0] d);
    tick(lat);
    rd_valid = 1'b1;
    rd_data  = d;
    tick(1);
    rd_valid = 1'b0;
  endtask

  function automatic logic [23:0] wq_at(input int i);
    return (wq.size() > i) ? wq[i] : 24'hFFFFFF;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; in_valid = 1'b0;
    in_data = 8'h0; out_ready = 1'b0; rd_valid = 1'b0; rd_data = 8'h0;
    tick(2);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd_en",     rd_en,     1'b0);
    chk("rst_wr_en",     wr_en,     1'b0);
    chk("rst_errs",      {stall_err, proto_err}, 2'b00);
    chk("rst_rd_addr",   rd_addr,   16'h0);
    rst_n = 1'b1;
    tick(1);

    // Write 0x4002.. with three data bytes
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h40);
    drive(0, 0, 1, 8'h02);
    drive(0, 0, 1, 8'h11);
    chk("wr1_en",   wr_en,   1'b1);
    chk("wr1_addr", wr_addr, 16'h4002);
    chk("wr1_data", wr_data, 8'h11);
    drive(0, 0, 1, 8'h22);
    drive(0, 0, 1, 8'h33);
    drive(0, 1, 0, 8'h00);
    tick(1);
    chk("wr_busy_end", busy, 1'b0);
    chk("wr_count",    wq.size(), 3);
    chk("wr_0",        wq_at(0), 24'h4002_11);
    chk("wr_1",        wq_at(1), 24'h4003_22);
    chk("wr_2",        wq_at(2), 24'h4004_33);
    chk("wr_no_rd",    rd_cnt, 0);

    // Read 0x0000 and 0x0001, responder latency 3
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h80);
    drive(0, 0, 1, 8'h00);
    chk("rd1_en",   rd_en,   1'b1);
    chk("rd1_addr", rd_addr, 16'h0000);
    respond(3, 8'hAB);
    chk("rd1_ov",   out_valid, 1'b1);
    chk("rd1_data", out_data,  8'hAB);
    tick(2);
    chk("rd1_hold_ov",   out_valid, 1'b1);
    chk("rd1_hold_data", out_data,  8'hAB);
    chk("rd1_no_reissue", rd_cnt, 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("rd2_en",   rd_en,     1'b1);
    chk("rd2_addr", rd_addr,   16'h0001);
    chk("rd2_ovlo", out_valid, 1'b0);
    respond(3, 8'hCD);
    chk("rd2_ov",   out_valid, 1'b1);
    chk("rd2_data", out_data,  8'hCD);
    drive(0, 1, 0, 8'h00);
    chk("rd_end_ov",   out_valid, 1'b0);
    chk("rd_end_busy", busy,      1'b0);
    chk("rd_count",    rd_cnt,    2);

    // Address wrap 0x7FFF -> 0x0000
    wq.delete();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h7F);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h02);
    drive(0, 1, 0, 8'h00);
    tick(1);
    chk("wrap_count", wq.size(), 2);
    chk("wrap_0",     wq_at(0), 24'h7FFF_01);
    chk("wrap_1",     wq_at(1), 24'h0000_02);
    chk("bit15",      bit15_viol, 0);

    // frame_end while a read is outstanding -> DRAIN
    ov_seen = 1'b0;
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h80);
    drive(0, 0, 1, 8'h10);
    chk("drn_rd_addr", rd_addr, 16'h0010);
    tick(1);
    drive(0, 1, 0, 8'h00);
    chk("drn_busy", busy, 1'b1);
    tick(2);
    drive(1, 0, 0, 8'h00);
    chk("drn_proto", proto_err, 1'b1);
    chk("drn_stay",  busy,      1'b1);
    tick(6);
    chk("drn_busy_pre", busy, 1'b1);
    rd_valid = 1'b1; rd_data = 8'h77;
    tick(1);
    rd_valid = 1'b0;
    chk("drn_idle", busy,    1'b0);
    chk("drn_noov", ov_seen, 1'b0);

    // Stall flag with STALL_CYCLES = 8
    drive(1, 0, 0, 8'h00);
    chk("stl_clr_stall", stall_err, 1'b0);
    chk("stl_clr_proto", proto_err, 1'b0);
    drive(0, 0, 1, 8'h80);
    drive(0, 0, 1, 8'h20);
    tick(6);
    chk("stl_early", stall_err, 1'b0);
    tick(3);
    chk("stl_set", stall_err, 1'b1);
    respond(11, 8'h5A);
    chk("stl_ov",     out_valid, 1'b1);
    chk("stl_data",   out_data,  8'h5A);
    chk("stl_sticky", stall_err, 1'b1);
    drive(0, 1, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    chk("stl_cleared", stall_err, 1'b0);
    drive(0, 1, 0, 8'h00);

    // Stray byte in IDLE
    drive(0, 0, 1, 8'h55);
    chk("idle_byte_proto", proto_err, 1'b1);
    chk("idle_byte_busy",  busy,      1'b0);

    // Reset in the middle of a read, then a fresh write
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h80);
    drive(0, 0, 1, 8'h30);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  busy,      1'b0);
    chk("mid_rst_addr",  rd_addr,   16'h0);
    chk("mid_rst_proto", proto_err, 1'b0);
    chk("mid_rst_ov",    out_valid, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    drive(1, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h05);
    drive(0, 1, 1, 8'hEE);
    chk("post_rst_wr_en",   wr_en,   1'b1);
    chk("post_rst_wr_addr", wr_addr, 16'h0005);
    chk("post_rst_wr_data", wr_data, 8'hEE);
    chk("post_rst_idle",    busy,    1'b0);
    tick(1);
    chk("rd_addr_stable", addr_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
